pipe_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage LC-3b pipeline; drives the load and bubble-insert controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It is the control-side counterpart of the pipeline latches, which carry data but do not decide when to load. It arbitrates memory-wait stalls, load-use bubbles and taken-branch squashes. It also keeps stall/flush performance counters and a memory-hang watchdog.

---
 rtl/pipe_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage LC-3b pipeline.
//
// Decides, every cycle, whether the PC and each pipeline register loads and
// whether IF/ID, ID/EX and EX/MEM capture a NOP control word instead of their
// input. Arbitrates memory-wait freezes, load-use bubbles and taken-branch
// squashes. Also keeps saturating stall/flush counters and a sticky watchdog
// that locks the pipe if memory never answers.
//
// Ports:
//   clk, reset_n                  clock (rising edge), async active-low reset
//   imem_read, imem_resp          IF fetch request / instruction memory response
//   dmem_req, dmem_resp           MEM load/store pending / data memory response
//   id_src1, id_src2              ID source register numbers
//   id_use_src1, id_use_src2      ID source actually read
//   ex_dest, ex_is_load           EX destination register / EX holds a load
//   br_taken                      MEM resolved a taken control transfer
//   pc_ld .. mem_wb_ld            load enables for PC and pipeline registers
//   if_id_flush .. ex_mem_flush   insert NOP control word
//   mem_timeout                   sticky watchdog flag
//   stall_cnt, flush_cnt          saturating performance counters
module pipe_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 imem_read,
  input  logic                 imem_resp,
  input  logic                 dmem_req,
  input  logic                 dmem_resp,
  input  logic [2:0]           id_src1,
  input  logic [2:0]           id_src2,
  input  logic                 id_use_src1,
  input  logic                 id_use_src2,
  input  logic [2:0]           ex_dest,
  input  logic                 ex_is_load,
  input  logic                 br_taken,
  output logic                 pc_ld,
  output logic                 if_id_ld,
  output logic                 id_ex_ld,
  output logic                 ex_mem_ld,
  output logic                 mem_wb_ld,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 ex_mem_flush,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  localparam int unsigned WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT);

  typedef enum logic [1:0] {StRun, StWait, StHung} state_e;

  state_e               state_q, state_d;
  logic [WaitW-1:0]     wait_ctr_q, wait_ctr_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
  logic                 mem_timeout_q, mem_timeout_d;

  logic mem_ready, lu_haz, active;
  logic do_stall, do_flush;

  assign mem_ready = (!imem_read || imem_resp) && (!dmem_req || dmem_resp);

  // R0 is architectural, so a match on register 0 is a genuine hazard.
  assign lu_haz = ex_is_load && ((id_use_src1 && (id_src1 == ex_dest)) ||
                                 (id_use_src2 && (id_src2 == ex_dest)));

  assign active = (state_q != StHung);

  // A taken branch squashes the ID instruction, so it overrides the bubble.
  assign do_flush = active && mem_ready && br_taken;
  assign do_stall = active && (!mem_ready || lu_haz) && !do_flush;

  // Output decode; everything is held off during reset and once hung.
  always_comb begin
    pc_ld        = 1'b0;
    if_id_ld     = 1'b0;
    id_ex_ld     = 1'b0;
    ex_mem_ld    = 1'b0;
    mem_wb_ld    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (reset_n && active && mem_ready) begin
      if (br_taken) begin
        pc_ld        = 1'b1;
        if_id_ld     = 1'b1;
        id_ex_ld     = 1'b1;
        ex_mem_ld    = 1'b1;
        mem_wb_ld    = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (lu_haz) begin
        id_ex_ld    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_ld   = 1'b1;
        mem_wb_ld   = 1'b1;
      end else begin
        pc_ld     = 1'b1;
        if_id_ld  = 1'b1;
        id_ex_ld  = 1'b1;
        ex_mem_ld = 1'b1;
        mem_wb_ld = 1'b1;
      end
    end
  end

  // Next-state and watchdog.
  always_comb begin
    state_d       = state_q;
    wait_ctr_d    = wait_ctr_q;
    mem_timeout_d = mem_timeout_q;
    unique case (state_q)
      StRun: begin
        wait_ctr_d = '0;
        if (!mem_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_ready) begin
          state_d    = StRun;
          wait_ctr_d = '0;
        end else if (wait_ctr_q == TimeoutVal) begin
          state_d       = StHung;
          mem_timeout_d = 1'b1;
        end else begin
          wait_ctr_d = wait_ctr_q + WaitW'(1);
        end
      end
      StHung: begin
        state_d       = StHung;
        mem_timeout_d = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_ctr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StRun;
      wait_ctr_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_ctr_q    <= wait_ctr_d;
      mem_timeout_q <= mem_timeout_d;
      if (do_stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      if (do_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (CNT_WIDTH=4, TIMEOUT=4). Inputs change just
// after the falling edge; combinational outputs are checked 1 time unit later
// and counters after the following falling edge.
module tb_pipe_ctrl;

  localparam int unsigned CW = 4;

  // {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_fl, id_ex_fl, ex_mem_fl}
  localparam logic [7:0] C_FRZ = 8'b00000_000;
  localparam logic [7:0] C_RUN = 8'b11111_000;
  localparam logic [7:0] C_BR  = 8'b11111_111;
  localparam logic [7:0] C_BUB = 8'b00111_010;

  logic clk = 1'b0;
  logic reset_n;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic [2:0] id_src1, id_src2, ex_dest;
  logic id_use_src1, id_use_src2, ex_is_load, br_taken;
  logic pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0] ctrl;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign ctrl = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
                 if_id_flush, id_ex_flush, ex_mem_flush};

  pipe_ctrl #(.CNT_WIDTH(CW), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .ex_dest(ex_dest), .ex_is_load(ex_is_load), .br_taken(br_taken),
    .pc_ld(pc_ld), .if_id_ld(if_id_ld), .id_ex_ld(id_ex_ld),
    .ex_mem_ld(ex_mem_ld), .mem_wb_ld(mem_wb_ld),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
    #1;
  endtask

  task automatic no_haz();
    id_src1 = 3'd0; id_src2 = 3'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
    ex_dest = 3'd0; ex_is_load = 1'b0; br_taken = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    imem_read = 1'b1; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    no_haz();
    #1;
    // Reset forces all controls low even with memory ready.
    chk("reset_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("reset_stall", 32'(stall_cnt), 0);
    chk("reset_flush", 32'(flush_cnt), 0);
    chk("reset_tmo", 32'(mem_timeout), 0);
    cyc(2);
    reset_n = 1'b1;
    #1;

    // Idle run.
    chk("idle_ctrl", 32'(ctrl), 32'(C_RUN));
    cyc(3);
    chk("idle_ctrl2", 32'(ctrl), 32'(C_RUN));
    chk("idle_stall", 32'(stall_cnt), 0);
    chk("idle_flush", 32'(flush_cnt), 0);

    // Instruction memory wait for 3 cycles.
    imem_resp = 1'b0; #1;
    chk("iwait_c0", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    chk("iwait_c1", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    chk("iwait_c2", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    chk("iwait_stall", 32'(stall_cnt), 3);
    imem_resp = 1'b1; #1;
    chk("iwait_resume", 32'(ctrl), 32'(C_RUN));
    cyc(1);
    chk("iwait_run", 32'(ctrl), 32'(C_RUN));
    chk("iwait_stall_hold", 32'(stall_cnt), 3);

    // Load-use on src2.
    ex_is_load = 1'b1; ex_dest = 3'd3; id_src2 = 3'd3; id_use_src2 = 1'b1; #1;
    chk("lu_bubble", 32'(ctrl), 32'(C_BUB));
    cyc(1);
    chk("lu_stall", 32'(stall_cnt), 4);
    id_use_src2 = 1'b0; #1;
    chk("lu_unused", 32'(ctrl), 32'(C_RUN));
    cyc(1);
    chk("lu_unused_stall", 32'(stall_cnt), 4);
    // R0 is a real register.
    ex_dest = 3'd0; id_src1 = 3'd0; id_use_src1 = 1'b1; #1;
    chk("lu_r0", 32'(ctrl), 32'(C_BUB));
    cyc(1);
    chk("lu_r0_stall", 32'(stall_cnt), 5);

    // Branch overrides load-use.
    br_taken = 1'b1; #1;
    chk("br_ctrl", 32'(ctrl), 32'(C_BR));
    cyc(1);
    chk("br_flush", 32'(flush_cnt), 1);
    chk("br_stall", 32'(stall_cnt), 5);
    // Branch while data memory is busy: frozen until the response.
    dmem_req = 1'b1; dmem_resp = 1'b0; #1;
    chk("br_dwait_c0", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    chk("br_dwait_c1", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    chk("br_dwait_flush", 32'(flush_cnt), 1);
    chk("br_dwait_stall", 32'(stall_cnt), 7);
    dmem_resp = 1'b1; #1;
    chk("br_dresp_ctrl", 32'(ctrl), 32'(C_BR));
    cyc(1);
    chk("br_dresp_flush", 32'(flush_cnt), 2);
    chk("br_dresp_stall", 32'(stall_cnt), 7);

    // Stall counter saturation via repeated bubbles.
    no_haz(); dmem_req = 1'b0; dmem_resp = 1'b0;
    ex_is_load = 1'b1; ex_dest = 3'd5; id_src1 = 3'd5; id_use_src1 = 1'b1;
    cyc(7);
    chk("sat_14", 32'(stall_cnt), 14);
    cyc(3);
    chk("sat_15", 32'(stall_cnt), 15);
    no_haz(); #1;

    // Watchdog: data memory never answers.
    dmem_req = 1'b1; dmem_resp = 1'b0;
    cyc(5);
    chk("wd_not_yet", 32'(mem_timeout), 0);
    chk("wd_frozen", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    chk("wd_timeout", 32'(mem_timeout), 1);
    dmem_resp = 1'b1; br_taken = 1'b1; #1;
    chk("hung_ctrl", 32'(ctrl), 32'(C_FRZ));
    cyc(2);
    chk("hung_ctrl2", 32'(ctrl), 32'(C_FRZ));
    chk("hung_tmo", 32'(mem_timeout), 1);
    chk("hung_flush_hold", 32'(flush_cnt), 2);
    chk("hung_stall_hold", 32'(stall_cnt), 15);

    // Asynchronous reset mid-cycle clears everything immediately.
    #2;
    reset_n = 1'b0; #1;
    chk("areset_tmo", 32'(mem_timeout), 0);
    chk("areset_stall", 32'(stall_cnt), 0);
    chk("areset_flush", 32'(flush_cnt), 0);
    chk("areset_ctrl", 32'(ctrl), 32'(C_FRZ));
    cyc(1);
    reset_n = 1'b1; br_taken = 1'b0; dmem_req = 1'b0; #1;
    chk("post_reset_ctrl", 32'(ctrl), 32'(C_RUN));
    cyc(1);
    chk("post_reset_tmo", 32'(mem_timeout), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global time bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "time limit");
  end

endmodule
